// File: rtl/input_wait_controller_pkg.sv
// Shared encodings for the INPUT wait handshake.
// The control unit imports the same state codes and opcode.
package input_wait_controller_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2,
    DONE         = 2'd3
  } iw_state_t;

  localparam logic [3:0] OPC_INPUT = 4'b1101;

endpackage

// File: rtl/input_debouncer.sv
// Level debouncer: pulses acc_o once level_i has matched target_i for
// DEBOUNCE_CYCLES consecutive enabled cycles; any mismatch restarts the count.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic level_i,
  input  logic target_i,
  output logic acc_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             match;

  assign match = en_i && (level_i == target_i);
  assign acc_o = match && (cnt_q == LAST);

  // Disabled, mismatching or accepting cycles all leave the counter at zero.
  always_comb begin
    cnt_d = '0;
    if (match && !acc_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/input_wait_controller.sv
// Stalls the PC while an INPUT instruction waits for a debounced press/release
// on the selected switch, then returns the word captured at the press.
// Optional wait limit: define INPUT_TIMEOUT_EN.
module input_wait_controller
  import input_wait_controller_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int CH_W            = 2,
  parameter int DATA_W          = 16,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic [NUM_CH-1:0] switch,
  input  logic [DATA_W-1:0] in_data,
  output logic              stall,
  output logic              data_valid,
  output logic [31:0]       data_out,
  output logic              err
);

  localparam int SW_W = 1 << CH_W;

  if (DEBOUNCE_CYCLES < 1 || SW_W < NUM_CH || TIMEOUT_CYCLES < 1 || DATA_W > 32)
  begin : g_param_check
    $error("input_wait_controller: invalid parameter set");
  end

  iw_state_t         state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic [SW_W-1:0]   sw_pad;
  logic              waiting, level, acc, timeout;

  // Padding lets an out-of-range ch_q index safely (it only occurs in DONE).
  assign sw_pad  = SW_W'(switch);
  assign level   = sw_pad[ch_q];
  assign waiting = (state_q == WAIT_PRESS) || (state_q == WAIT_RELEASE);

  input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .reset   (reset),
    .en_i    (waiting),
    .level_i (level),
    .target_i(state_q == WAIT_PRESS),
    .acc_o   (acc)
  );

`ifdef INPUT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wait_q;

  // Runs across both wait states; only leaving the wait clears it.
  always_ff @(posedge clk) begin
    if (reset || !waiting) wait_q <= '0;
    else                   wait_q <= wait_q + 1'b1;
  end

  assign timeout = waiting && (wait_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          ch_d  = ch_sel;
          err_d = 1'b0;
          if (32'(ch_sel) >= NUM_CH) begin
            state_d = DONE;
            err_d   = 1'b1;
            data_d  = '0;
          end else begin
            state_d = WAIT_PRESS;
          end
        end
      end
      WAIT_PRESS: begin
        if (timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
          data_d  = '0;
        end else if (acc) begin
          data_d  = in_data;
          state_d = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
          data_d  = '0;
        end else if (acc) begin
          state_d = DONE;
        end
      end
      // req here still belongs to the completing instruction.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign stall      = waiting || ((state_q == IDLE) && req);
  assign data_valid = (state_q == DONE);
  assign err        = data_valid && err_q;
  assign data_out   = 32'(data_q);

endmodule

// File: tb/tb_input_wait_controller.sv
// Directed bench for input_wait_controller: vector table for the main handshakes
// plus hand sequences for the bad-channel and optional timeout paths.
module tb_input_wait_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, req_b;
  logic [1:0]  ch_a, ch_b;
  logic [3:0]  sw;
  logic [15:0] in_d;
  logic        stall_a, dv_a, err_a, stall_b, dv_b, err_b;
  logic [31:0] dout_a, dout_b;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  input_wait_controller #(
    .NUM_CH(4), .CH_W(2), .DATA_W(16), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(20)
  ) dut_a (
    .clk(clk), .reset(rst), .req(req_a), .ch_sel(ch_a), .switch(sw),
    .in_data(in_d), .stall(stall_a), .data_valid(dv_a), .data_out(dout_a), .err(err_a)
  );

  input_wait_controller #(
    .NUM_CH(3), .CH_W(2), .DATA_W(16), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(20)
  ) dut_b (
    .clk(clk), .reset(rst), .req(req_b), .ch_sel(ch_b), .switch(sw[2:0]),
    .in_data(in_d), .stall(stall_b), .data_valid(dv_b), .data_out(dout_b), .err(err_b)
  );

  typedef struct {
    logic        rst;
    logic        req;
    logic [1:0]  ch;
    logic [3:0]  sw;
    logic [15:0] d;
    logic        est;
    logic        edv;
    logic        eerr;
    logic [31:0] edout;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic r, input logic q, input logic [1:0] c,
                     input logic [3:0] s, input logic [15:0] d, input logic est,
                     input logic edv, input logic eerr, input logic [31:0] edout);
    vec_t v;
    v.rst = r; v.req = q; v.ch = c; v.sw = s; v.d = d;
    v.est = est; v.edv = edv; v.eerr = eerr; v.edout = edout;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic st, input logic dv,
                       input logic er, input logic [31:0] dout);
    @(negedge clk);
    chk({tag, ".stall"}, 32'(stall_b), 32'(st));
    chk({tag, ".dv"},    32'(dv_b),    32'(dv));
    chk({tag, ".err"},   32'(err_b),   32'(er));
    chk({tag, ".dout"},  dout_b,       dout);
    next_cycle();
  endtask

  task automatic chk_a(input string tag, input logic st, input logic dv,
                       input logic er, input logic [31:0] dout);
    @(negedge clk);
    chk({tag, ".stall"}, 32'(stall_a), 32'(st));
    chk({tag, ".dv"},    32'(dv_a),    32'(dv));
    chk({tag, ".err"},   32'(err_a),   32'(er));
    chk({tag, ".dout"},  dout_a,       dout);
    next_cycle();
  endtask

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; ch_a = '0; ch_b = '0; sw = '0; in_d = '0;

    // Test 1: basic handshake on ch2, data_valid in cycle 9; req held in DONE is ignored.
    add(1, 0, 1, 2, 4'b0000, 16'h00A5, 1, 0, 0, 32'h0);
    add(4, 0, 0, 2, 4'b0100, 16'h00A5, 1, 0, 0, 32'h0);
    add(4, 0, 0, 2, 4'b0000, 16'hFFFF, 1, 0, 0, 32'hA5);
    add(1, 0, 1, 2, 4'b0000, 16'hFFFF, 0, 1, 0, 32'hA5);
    add(1, 0, 0, 0, 4'b0000, 16'h0000, 0, 0, 0, 32'hA5);
    // Test 2: bounce 1,0,1,1,0 then steady high; capture at the 4th consecutive high.
    add(1, 0, 1, 2, 4'b0000, 16'h0011, 1, 0, 0, 32'hA5);
    add(1, 0, 0, 2, 4'b0100, 16'h0011, 1, 0, 0, 32'hA5);
    add(1, 0, 0, 2, 4'b0000, 16'h0011, 1, 0, 0, 32'hA5);
    add(2, 0, 0, 2, 4'b0100, 16'h0011, 1, 0, 0, 32'hA5);
    add(1, 0, 0, 2, 4'b0000, 16'h0011, 1, 0, 0, 32'hA5);
    add(1, 0, 0, 2, 4'b0100, 16'h0022, 1, 0, 0, 32'hA5);
    add(1, 0, 0, 2, 4'b0100, 16'h0033, 1, 0, 0, 32'hA5);
    add(1, 0, 0, 2, 4'b0100, 16'h0044, 1, 0, 0, 32'hA5);
    add(1, 0, 0, 2, 4'b0100, 16'h0055, 1, 0, 0, 32'hA5);
    add(4, 0, 0, 2, 4'b0000, 16'h0066, 1, 0, 0, 32'h55);
    add(1, 0, 0, 0, 4'b0000, 16'h0000, 0, 1, 0, 32'h55);
    add(1, 0, 0, 0, 4'b0000, 16'h0000, 0, 0, 0, 32'h55);
    // Test 3: waiting on ch1 while ch0/ch3 toggle; then ch1 completes.
    add(1, 0, 1, 1, 4'b0000, 16'h0BEE, 1, 0, 0, 32'h55);
    add(5, 0, 0, 1, 4'b1001, 16'h0BEE, 1, 0, 0, 32'h55);
    add(5, 0, 0, 1, 4'b0000, 16'h0BEE, 1, 0, 0, 32'h55);
    add(4, 0, 0, 1, 4'b0010, 16'h0BEE, 1, 0, 0, 32'h55);
    add(4, 0, 0, 1, 4'b1001, 16'h0BEE, 1, 0, 0, 32'hBEE);
    add(1, 0, 0, 0, 4'b0000, 16'h0000, 0, 1, 0, 32'hBEE);
    add(1, 0, 0, 0, 4'b0000, 16'h0000, 0, 0, 0, 32'hBEE);
    // Test 5: reset in WAIT_RELEASE aborts; a new req restarts from WAIT_PRESS.
    add(1, 0, 1, 0, 4'b0000, 16'h1234, 1, 0, 0, 32'hBEE);
    add(4, 0, 0, 0, 4'b0001, 16'h1234, 1, 0, 0, 32'hBEE);
    add(1, 0, 0, 0, 4'b0000, 16'h1234, 1, 0, 0, 32'h1234);
    add(1, 1, 0, 0, 4'b0000, 16'h1234, 1, 0, 0, 32'h1234);
    add(1, 0, 0, 0, 4'b0000, 16'h1234, 0, 0, 0, 32'h0);
    add(1, 0, 1, 0, 4'b0000, 16'h5678, 1, 0, 0, 32'h0);
    add(4, 0, 0, 0, 4'b0001, 16'h5678, 1, 0, 0, 32'h0);
    add(4, 0, 0, 0, 4'b0000, 16'h5678, 1, 0, 0, 32'h5678);
    add(1, 0, 0, 0, 4'b0000, 16'h0000, 0, 1, 0, 32'h5678);
    add(1, 0, 0, 0, 4'b0000, 16'h0000, 0, 0, 0, 32'h5678);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_a("reset_a", 0, 0, 0, 32'h0);
    @(negedge clk);
    chk("reset_b.stall", 32'(stall_b), 32'h0);
    chk("reset_b.dv",    32'(dv_b),    32'h0);
    chk("reset_b.dout",  dout_b,       32'h0);
    next_cycle();

    foreach (vecs[i]) begin
      rst = vecs[i].rst; req_a = vecs[i].req; ch_a = vecs[i].ch;
      sw = vecs[i].sw; in_d = vecs[i].d;
      chk_a($sformatf("vec%0d", i), vecs[i].est, vecs[i].edv, vecs[i].eerr, vecs[i].edout);
    end
    rst = 1'b0; req_a = 1'b0; sw = '0;

    // Test 4 on the 3-channel instance: a good capture first, then ch_sel=3.
    req_b = 1'b1; ch_b = 2'd1; in_d = 16'h7777;
    chk_b("b_req", 1, 0, 0, 32'h0);
    req_b = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sw = (k < 4) ? 4'b0010 : 4'b0000;
      chk_b($sformatf("b_wait%0d", k), 1, 0, 0, (k < 4) ? 32'h0 : 32'h7777);
    end
    chk_b("b_done", 0, 1, 0, 32'h7777);
    req_b = 1'b1; ch_b = 2'd3; in_d = 16'h4321;
    chk_b("bad_req", 1, 0, 0, 32'h7777);
    req_b = 1'b0;
    chk_b("bad_done", 0, 1, 1, 32'h0);
    chk_b("bad_idle", 0, 0, 0, 32'h0);

`ifdef INPUT_TIMEOUT_EN
    // Test 6: no press; 20 wait cycles then DONE with err and zero data.
    req_a = 1'b1; ch_a = 2'd0; sw = '0; in_d = 16'hABCD;
    chk_a("to_req", 1, 0, 0, 32'h5678);
    req_a = 1'b0;
    for (int k = 0; k < 20; k++) chk_a($sformatf("to_wait%0d", k), 1, 0, 0, 32'h5678);
    chk_a("to_done", 0, 1, 1, 32'h0);
    chk_a("to_idle", 0, 0, 0, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/input_wait_controller.md
Name: input_wait_controller

Overview:
Parametrised successor to the single-switch INPUT lock in the processor top level. It stalls the PC while an INPUT instruction waits for a debounced press-then-release on one of NUM_CH switches, chosen by the instruction. It captures the input word at the debounced press. It then returns the word for register writeback in a single release cycle. The block sits between the control unit (INPUT decode), the board switches/input bus, and the PC hold mux.

Parameters:
NUM_CH, 4, number of independent handshake switches
CH_W, 2, width of channel select; must satisfy 2**CH_W >= NUM_CH
DATA_W, 16, width of the input data bus, zero-extended to 32 bits
DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a level change (>=1)
TIMEOUT_CYCLES, 1000000, wait limit when INPUT_TIMEOUT_EN is defined

Ports:
clk  input  1  system clock; all state changes on posedge
reset  input  1  synchronous, active-high reset
req  input  1  INPUT opcode decoded for the current instruction
ch_sel  input  CH_W  switch channel named by the instruction
switch  input  NUM_CH  raw switch levels (already synchronised upstream)
in_data  input  DATA_W  input data bus (board slide switches)
stall  output  1  hold PC / suppress writeback
data_valid  output  1  writeback strobe for the INPUT result
data_out  output  32  {zeros, captured in_data}
err  output  1  with data_valid: bad channel or timeout

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; counters 0; captured data 0.
  - stall=0, data_valid=0, err=0, data_out=0.
  - Reset mid-wait aborts the wait with no data_valid pulse.
- FSM states: IDLE, WAIT_PRESS, WAIT_RELEASE, DONE.
- IDLE:
  - If req=1: latch ch_sel into ch_q, clear the debounce counter.
  - If ch_sel>=NUM_CH: go to DONE with err set and data 0. Otherwise go to WAIT_PRESS.
- stall is combinational: (state==WAIT_PRESS || state==WAIT_RELEASE) || (state==IDLE && req). The PC therefore holds in the same cycle the INPUT is first seen.
- Debounce:
  - The counter increments each cycle switch[ch_q] equals the target level (1 in WAIT_PRESS, 0 in WAIT_RELEASE).
  - Any mismatching cycle resets the counter to 0.
  - The level is accepted when the counter reaches DEBOUNCE_CYCLES-1 and still matches; the counter then clears.
- WAIT_PRESS: on accepted press, capture in_data into the data register and go to WAIT_RELEASE.
- WAIT_RELEASE: on accepted release, go to DONE. in_data changes after the press are ignored.
- DONE (one cycle):
  - stall=0, data_valid=1, data_out=captured data, err as latched.
  - Next state is IDLE.
  - req is ignored in DONE, because it belongs to the completing instruction.
- data_out holds the last captured value until the next capture or reset.
- Minimum latency with no bounce: req accepted at cycle 0 gives data_valid at cycle 2*DEBOUNCE_CYCLES+1 (press and release each held from cycle 1 onward).
- A switch already high when req arrives counts as a press; the handshake still requires the release.
- Only switch[ch_q] matters; other channels are ignored while waiting.

Optional Feature:
INPUT_TIMEOUT_EN
- Defined:
  - A wait counter clears on entry to WAIT_PRESS and increments in WAIT_PRESS and WAIT_RELEASE.
  - At TIMEOUT_CYCLES it forces DONE with err=1 and data_out=0, capture discarded.
  - The counter does not clear between press and release.
- Undefined: no counter; the block waits indefinitely and err is asserted only for a bad channel.

Decomposition:
- Shared package: state encoding constants (IDLE/WAIT_PRESS/WAIT_RELEASE/DONE as 2-bit) and the INPUT opcode constant 4'b1101. These are shared with the control unit.
- One natural sub-module: input_debouncer. It takes a level, a target and an enable, and outputs an accepted pulse plus a counter clear. It is parametrised by DEBOUNCE_CYCLES and instantiated once on the muxed switch[ch_q].

Test Plan:
1. Basic handshake: DEBOUNCE_CYCLES=4; req=1, ch_sel=2, in_data=16'h00A5; switch[2] high for 4 cycles, then low for 4 cycles.
   - Required: stall=1 throughout; data_valid=1 exactly once, in cycle 9.
   - Required: data_out=32'h000000A5, err=0.
2. Bounce: switch[2] toggles 1,0,1,1,0 then steady 1.
   - Required: no capture until 4 consecutive highs; in_data changed during the bounce is captured at the accepted edge.
3. Wrong channel: ch_q=1 while switch[0] and switch[3] toggle.
   - Required: stall stays 1, no data_valid.
   - Then switch[1] press/release gives completion.
4. Bad channel: NUM_CH=3, ch_sel=3.
   - Required: data_valid=1, err=1, data_out=0 one cycle after req; stall high only in the req cycle.
5. Reset mid-wait: reset=1 in WAIT_RELEASE.
   - Required: next cycle stall=0, data_valid=0, data_out=0; a new req restarts from WAIT_PRESS.
6. INPUT_TIMEOUT_EN: TIMEOUT_CYCLES=20, no press.
   - Required: data_valid=1, err=1, data_out=0 at wait cycle 20; the block then returns to IDLE.
